// File: rtl/wb_timer.sv
// wb_timer: Wishbone-style memory-mapped down-counting timer with prescaler.
//
// Register map (word index taken from wb_adr[TIMER_ADDR_LSB+1:TIMER_ADDR_LSB]):
//   0 CTRL   : bit0 EN, bit1 IE, bit2 AUTO, bits[15:8] PRESC
//   1 RELOAD : 32-bit reload value used when AUTO=1
//   2 COUNT  : 32-bit down counter
//   3 STATUS : bit0 ZERO (write 1 to clear)
//
// Ports:
//   sys_clk  : system clock, all logic on the rising edge
//   reset    : synchronous active-high reset
//   wb_stb   : strobe / chip select
//   wb_we    : 1 = write, 0 = read
//   wb_adr   : byte address, only the two register-select bits are decoded
//   wb_dat_i : write data (full-word writes only)
//   wb_ack   : single-cycle acknowledge, one cycle after a qualifying strobe
//   wb_dat_o : read data in the ack cycle, 32'h0 otherwise
//   irq      : registered level interrupt, ZERO & IE
//
// Handshake: a cycle with wb_stb=1 and wb_ack=0 is a qualifying access. Writes
// take effect at the end of that cycle; wb_ack (and read data) follow in the
// next cycle. Holding wb_stb high therefore yields one access every two cycles.
module wb_timer #(
  parameter int TIMER_ADDR_LSB = 2
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack,
  output logic [31:0] wb_dat_o,
  output logic        irq
);

  localparam logic [1:0] SEL_CTRL   = 2'd0;
  localparam logic [1:0] SEL_RELOAD = 2'd1;
  localparam logic [1:0] SEL_COUNT  = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        auto_q, auto_d;
  logic [7:0]  presc_cfg_q, presc_cfg_d;
  logic [31:0] reload_q, reload_d;
  logic [31:0] count_q, count_d;
  logic        zero_q, zero_d;
  logic [7:0]  presc_q, presc_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_o_q, dat_o_d;
  logic        irq_q, irq_d;

  logic        access;
  logic        wr;
  logic [1:0]  sel;
  logic        tick;
  logic        en_clr;
  logic [31:0] rd_data;

  assign sel    = wb_adr[TIMER_ADDR_LSB+1:TIMER_ADDR_LSB];
  assign access = wb_stb & ~ack_q;
  assign wr     = access & wb_we;
  assign tick   = en_q & (presc_q == presc_cfg_q);

  always_comb begin
    rd_data = 32'h0;
    case (sel)
      SEL_CTRL:   rd_data = {16'h0, presc_cfg_q, 5'h0, auto_q, ie_q, en_q};
      SEL_RELOAD: rd_data = reload_q;
      SEL_COUNT:  rd_data = count_q;
      SEL_STATUS: rd_data = {31'h0, zero_q};
      default:    rd_data = 32'h0;
    endcase
  end

  always_comb begin
    en_d        = en_q;
    ie_d        = ie_q;
    auto_d      = auto_q;
    presc_cfg_d = presc_cfg_q;
    reload_d    = reload_q;
    count_d     = count_q;
    zero_d      = zero_q;
    presc_d     = presc_q;
    en_clr      = 1'b0;

    // Prescaler restarts on every tick, while disabled, and on any CTRL write.
    if (!en_q || tick || (wr && sel == SEL_CTRL)) begin
      presc_d = 8'h0;
    end else begin
      presc_d = presc_q + 8'd1;
    end

    // W1C first so that a same-cycle hardware set below wins.
    if (wr && sel == SEL_STATUS && wb_dat_i[0]) begin
      zero_d = 1'b0;
    end

    if (tick) begin
      if (count_q != 32'h0) begin
        count_d = count_q - 32'd1;
      end else begin
        zero_d = 1'b1;
        if (auto_q) begin
          count_d = reload_q;
        end else begin
          en_clr = 1'b1;
        end
      end
    end

    if (en_clr) begin
      en_d = 1'b0;
    end

    // Software writes come last: a CTRL write decides EN outright (re-arm wins),
    // and a COUNT write discards the tick update.
    if (wr) begin
      case (sel)
        SEL_CTRL: begin
          en_d        = wb_dat_i[0];
          ie_d        = wb_dat_i[1];
          auto_d      = wb_dat_i[2];
          presc_cfg_d = wb_dat_i[15:8];
        end
        SEL_RELOAD: reload_d = wb_dat_i;
        SEL_COUNT:  count_d  = wb_dat_i;
        default:    ;
      endcase
    end

    ack_d   = access;
    dat_o_d = access ? rd_data : 32'h0;
    irq_d   = zero_q & ie_q;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      en_q        <= 1'b0;
      ie_q        <= 1'b0;
      auto_q      <= 1'b0;
      presc_cfg_q <= 8'h0;
      reload_q    <= 32'h0;
      count_q     <= 32'h0;
      zero_q      <= 1'b0;
      presc_q     <= 8'h0;
      ack_q       <= 1'b0;
      dat_o_q     <= 32'h0;
      irq_q       <= 1'b0;
    end else begin
      en_q        <= en_d;
      ie_q        <= ie_d;
      auto_q      <= auto_d;
      presc_cfg_q <= presc_cfg_d;
      reload_q    <= reload_d;
      count_q     <= count_d;
      zero_q      <= zero_d;
      presc_q     <= presc_d;
      ack_q       <= ack_d;
      dat_o_q     <= dat_o_d;
      irq_q       <= irq_d;
    end
  end

  assign wb_ack   = ack_q;
  assign wb_dat_o = dat_o_q;
  assign irq      = irq_q;

endmodule
